// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, captures the returned word and hands it to the controller.
//
// Handshakes (both strict valid/ready, no combinational input-to-output path):
//   memory side:     imem_req/imem_addr held steady until an edge with
//                    imem_valid=1; imem_valid is ignored unless in FETCH.
//   downstream side: instr_valid stays high and instr stable until an edge
//                    with instr_ready=1; pcsrc/jump/branch_target are only
//                    looked at on that accept edge.
module ifetch_unit #(
  parameter int          n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_valid,
  output logic [31:0]  instr,
  output logic [5:0]   op,
  output logic [5:0]   funct,
  output logic [n-1:0] pc,
  output logic [n-1:0] pcplus4,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         pcsrc,
  input  logic         jump,
  input  logic [n-1:0] branch_target,
  output logic [31:0]  retired,
  output logic         fetch_err,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retired_q, retired_d;
  logic         err_q, err_d;
  logic [n-1:0] next_pc;

  // Sequential PC; wraps modulo 2^n, and the wrapped value is a legal PC.
  assign pcplus4 = pc_q + {{(n-3){1'b0}}, 3'd4};

  // Next-PC select on accept: jump beats branch, branch beats sequential.
  always_comb begin
    next_pc = pcplus4;
    if (jump) begin
      next_pc = {pcplus4[n-1:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc = branch_target;
    end
  end

  // State and datapath registers; async reset forces every output at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RESET;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    err_d     = err_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            // Misaligned target: keep the faulting instruction's PC visible.
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign fetch_err   = err_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, first fetch, backpressure, branch
// vs jump, memory latency, spurious valid, misaligned target, PC wrap and
// reset in the middle of a fetch.
module tb_ifetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] branch_target;
  logic [31:0] retired;
  logic        fetch_err;
  logic [1:0]  fsm_state;

  // second instance for the PC wrap case
  logic        reset1_n;
  logic        imem_req1;
  logic [31:0] imem_addr1;
  logic [31:0] instr1;
  logic [5:0]  op1;
  logic [5:0]  funct1;
  logic [31:0] pc1;
  logic [31:0] pcplus4_1;
  logic        instr_valid1;
  logic        instr_ready1;
  logic [31:0] retired1;
  logic        fetch_err1;
  logic [1:0]  fsm_state1;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.n(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .op(op), .funct(funct), .pc(pc), .pcplus4(pcplus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pcsrc(pcsrc), .jump(jump), .branch_target(branch_target),
    .retired(retired), .fetch_err(fetch_err), .fsm_state(fsm_state)
  );

  ifetch_unit #(.n(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset1_n),
    .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_rdata(32'h0000_0020), .imem_valid(1'b1),
    .instr(instr1), .op(op1), .funct(funct1), .pc(pc1), .pcplus4(pcplus4_1),
    .instr_valid(instr_valid1), .instr_ready(instr_ready1),
    .pcsrc(1'b0), .jump(1'b0), .branch_target(32'h0),
    .retired(retired1), .fetch_err(fetch_err1), .fsm_state(fsm_state1)
  );

  // clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle 1 unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; reset1_n = 1'b0;
    imem_rdata = '0; imem_valid = 1'b0;
    instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0; branch_target = '0;
    instr_ready1 = 1'b0;
    #1;
    chk("rst_imem_req_async", {31'd0, imem_req}, 32'd0);
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);

    // ---- reset release and zero-latency first fetch (ADD)
    reset_n = 1'b1;
    imem_rdata = 32'h0000_0020; imem_valid = 1'b1;
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid_low", {31'd0, instr_valid}, 32'd0);
    step();
    chk("first_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_op", {26'd0, op}, 32'd0);
    chk("first_funct", {26'd0, funct}, 32'h20);
    chk("first_pcplus4", pcplus4, 32'h4);
    imem_valid = 1'b0; imem_rdata = 32'h0;

    // ---- backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", instr, 32'h0000_0020);
      chk("bp_pc", pc, 32'h0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      chk("bp_retired", retired, 32'h0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("acc_retired", retired, 32'h1);
    chk("acc_valid_fall", {31'd0, instr_valid}, 32'd0);
    chk("acc_req_rise", {31'd0, imem_req}, 32'd1);
    chk("acc_addr", imem_addr, 32'h4);

    // ---- sequential instruction at pc=4 (SUB)
    imem_rdata = 32'h0000_0022; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("pc4_funct", {26'd0, funct}, 32'h22);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("seq_addr", imem_addr, 32'h8);

    // ---- branch at pc=8 (BEQ), taken to 0x40
    imem_rdata = 32'h1000_0003; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("beq_op", {26'd0, op}, 32'h04);
    pcsrc = 1'b1; branch_target = 32'h40; instr_ready = 1'b1;
    step();
    pcsrc = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
    chk("branch_addr", imem_addr, 32'h40);
    chk("branch_retired", retired, 32'h3);

    // ---- jump at pc=0x40 with pcsrc also set and a differing branch target
    imem_rdata = 32'h0800_0010; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("j_op", {26'd0, op}, 32'h02);
    chk("j_pcplus4", pcplus4, 32'h44);
    jump = 1'b1; pcsrc = 1'b1; branch_target = 32'h80; instr_ready = 1'b1;
    step();
    jump = 1'b0; pcsrc = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
    chk("jump_addr", imem_addr, 32'h40);
    chk("jump_retired", retired, 32'h4);

    // ---- memory latency 3: response in the 4th request cycle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat_valid_low", {31'd0, instr_valid}, 32'd0);
      chk("lat_req_held", {31'd0, imem_req}, 32'd1);
      chk("lat_addr_held", imem_addr, 32'h40);
    end
    imem_rdata = 32'h0000_0024; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("lat_valid_rise", {31'd0, instr_valid}, 32'd1);
    chk("lat_instr", instr, 32'h0000_0024);

    // ---- spurious imem_valid during HOLD
    imem_rdata = 32'hDEAD_BEEF; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("spur_instr", instr, 32'h0000_0024);
    chk("spur_valid", {31'd0, instr_valid}, 32'd1);

    // ---- misaligned branch target
    pcsrc = 1'b1; branch_target = 32'h42; instr_ready = 1'b1;
    step();
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", pc, 32'h40);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    chk("mis_retired", retired, 32'h5);
    chk("mis_state", {30'd0, fsm_state}, 32'd3);
    pcsrc = 1'b0; branch_target = 32'h0;
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_pc", pc, 32'h40);
    end
    imem_valid = 1'b0; instr_ready = 1'b0;

    // ---- reset clears the error asynchronously
    #2;
    reset_n = 1'b0;
    #1;
    chk("clr_err", {31'd0, fetch_err}, 32'd0);
    chk("clr_pc", pc, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("pending_req", {31'd0, imem_req}, 32'd1);

    // ---- reset mid-fetch, with a late response after release
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_req_drop", {31'd0, imem_req}, 32'd0);
    chk("mid_state", {30'd0, fsm_state}, 32'd0);
    chk("mid_instr", instr, 32'h0);
    chk("mid_retired", retired, 32'h0);
    chk("mid_pc", pc, 32'h0);
    imem_rdata = 32'h0000_0BAD; imem_valid = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("late_instr", instr, 32'h0);
    chk("late_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("late_still_fetch", {31'd0, instr_valid}, 32'd0);

    // ---- PC wrap on the second instance
    reset1_n = 1'b1;
    step();
    chk("wrap_addr", imem_addr1, 32'hFFFF_FFFC);
    chk("wrap_req", {31'd0, imem_req1}, 32'd1);
    step();
    chk("wrap_pcplus4", pcplus4_1, 32'h0);
    chk("wrap_valid", {31'd0, instr_valid1}, 32'd1);
    instr_ready1 = 1'b1;
    step();
    instr_ready1 = 1'b0;
    chk("wrap_next_addr", imem_addr1, 32'h0);
    chk("wrap_no_err", {31'd0, fetch_err1}, 32'd0);
    chk("wrap_req_next", {31'd0, imem_req1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the MIPS core, directly upstream of `controller`. It holds the program counter and issues word reads to instruction memory. It captures the returned word and presents `op`/`funct` to `controller` through a valid/ready handshake. It consumes `controller`'s `pcsrc` and `jump` decisions to pick the next PC when the current instruction is accepted.

## Interface
- `n`, 32, PC/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  n  word address of the request; equals `pc`
- `imem_rdata`  in  32  returned instruction word
- `imem_valid`  in  1  `imem_rdata` valid; sampled only while `imem_req`=1
- `instr`  out  32  captured instruction
- `op`  out  6  `instr[31:26]`, to `controller`
- `funct`  out  6  `instr[5:0]`, to `controller`
- `pc`  out  n  address of `instr`
- `pcplus4`  out  n  `pc + 4`, modulo 2^n
- `instr_valid`  out  1  `instr` valid for downstream
- `instr_ready`  in  1  downstream accepts `instr` this cycle
- `pcsrc`  in  1  branch taken; from `controller`
- `jump`  in  1  jump; from `controller`
- `branch_target`  in  n  `pcplus4 + (signimm << 2)`; from the datapath
- `retired`  out  32  count of accepted instructions
- `fetch_err`  out  1  sticky misaligned-PC error

## Operation
- States: RESET, FETCH, HOLD, ERROR.
- RESET:
  - Entered asynchronously while `reset_n`=0.
  - Moves to FETCH on the first rising edge with `reset_n`=1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_valid`=1: `instr`<=`imem_rdata`, go to HOLD.
  - Otherwise stay in FETCH, with `imem_req` and `imem_addr` held steady.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0; `instr` is stable.
  - On an edge with `instr_ready`=1 (accept):
    - `retired`<=`retired+1`, wrapping at 2^32.
    - Compute next PC:
      - if `jump`: {`pcplus4[n-1:28]`, `instr[25:0]`, 2'b00};
      - else if `pcsrc`: `branch_target`;
      - else: `pcplus4`.
    - If next PC[1:0]≠0: `fetch_err`<=1, `pc` unchanged, go to ERROR.
    - Otherwise `pc`<=next PC, go to FETCH.
  - Without `instr_ready`, stay in HOLD.
- ERROR:
  - `imem_req`=0, `instr_valid`=0, `fetch_err`=1.
  - Exits only via reset.
- Priority: `jump` over `pcsrc`. `pcsrc`, `jump` and `branch_target` are sampled only on the accept edge and ignored otherwise.
- `imem_valid` is ignored outside FETCH.
- `op`, `funct` and `pcplus4` are combinational from the registered `instr` and `pc`.
- Arithmetic: `pcplus4` wraps, e.g. 32'hFFFF_FFFC -> 32'h0000_0000. That wrapped value is a legal next PC.

## Timing
- Reset values:
  - `pc`=`RESET_PC`
  - `instr`=0
  - `retired`=0
  - `fetch_err`=0
  - `imem_req`=0
  - `instr_valid`=0
  - state=RESET
- Asserting `reset_n` low forces all outputs to their reset values immediately, without waiting for a clock edge. This includes mid-fetch: `imem_req` drops at once, and any memory response arriving afterwards is ignored.
- Edge 1 after reset release: state becomes FETCH and `imem_req` rises.
- With zero-latency memory (`imem_valid`=1 in the request cycle), `instr_valid` rises 1 cycle after `imem_req`.
- With memory latency L cycles, `instr_valid` rises L+1 cycles after `imem_req`.
- On the accept edge, `instr_valid` falls and `imem_req` rises with the new `pc`.
- Peak throughput: 1 instruction per 2 cycles.
- All outputs are registered state or combinational decode of registered state, so there is no combinational path from inputs to outputs.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0, memory returns 32'h0000_0020 (ADD, `funct`=100000) with zero latency.
  - `imem_req`=1 one cycle after release, with `imem_addr`=0.
  - Next cycle: `instr_valid`=1, `op`=000000, `funct`=100000, `pcplus4`=4.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles.
  - `instr`, `pc` and `instr_valid`=1 stay stable and `imem_req`=0 throughout.
  - On the first `instr_ready`=1 edge, `retired` goes 0->1.
- **Branch vs jump:**
  - At `pc`=8 with `pcsrc`=1 and `branch_target`=32'h40: next `imem_addr`=32'h40.
  - With `jump`=1 as well, `instr[25:0]`=26'h10 and `pcsrc`=1: next `imem_addr`=32'h40 from the jump path; also checked with a differing `branch_target`=32'h80.
- **Memory latency and spurious valid:**
  - Latency 3: `instr_valid` appears exactly 4 cycles after `imem_req`.
  - An `imem_valid` pulse during HOLD does not change `instr`.
- **Misaligned target and wrap:**
  - Accept with `pcsrc`=1, `branch_target`=32'h42: `fetch_err`=1, `imem_req` stays 0, `pc` unchanged; cleared only by reset.
  - Separately, `RESET_PC`=32'hFFFF_FFFC with sequential accept: next `imem_addr`=0.
- **Reset mid-fetch:** drive `reset_n`=0 while in FETCH with memory latency pending.
  - `imem_req` drops immediately and all outputs take their reset values.
  - A late `imem_valid` after release is ignored until the new FETCH state.
